// File: rtl/tpmem_pingpong.sv
// Ping-pong transposer: N rows of N*BW bits in, N columns out; first column 1 cycle after last row, stalls hold output.
// Optional TPMEM_DROP_CNT_EN adds o_drop_cnt, a saturating count of rows offered while o_ready=0.
module tpmem_pingpong #(
  parameter int BW = 12,
  parameter int N  = 16
) (
  input  logic            i_clk,
  input  logic            i_Reset,
  input  logic [N*BW-1:0] i_data,
  input  logic            i_enable,
  output logic            o_ready,
  output logic [N*BW-1:0] o_data,
  output logic            o_en,
`ifdef TPMEM_DROP_CNT_EN
  output logic [7:0]      o_drop_cnt,
`endif
  input  logic            i_out_ready
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic [N*BW-1:0] mem_q [2][N];

  logic            wb_q, wb_d, rb_q, rb_d;
  logic [AW-1:0]   wr_q, wr_d, rc_q, rc_d;
  logic [1:0]      full_q, full_d;
  logic            o_en_q, o_en_d;
  logic [N*BW-1:0] o_data_q, o_data_d;
  logic [N*BW-1:0] col;
  logic            wr_acc, ld;

  assign o_ready = ~full_q[wb_q];
  assign wr_acc  = i_enable & o_ready;
  assign ld      = full_q[rb_q] & (~o_en_q | i_out_ready);
  assign o_data  = o_data_q;
  assign o_en    = o_en_q;

  // Lane j of the column is element rc of row j in the read bank.
  always_comb begin
    col = '0;
    for (int j = 0; j < N; j++) begin
      col[(N-j)*BW-1 -: BW] = mem_q[rb_q][j][(N-1-int'(rc_q))*BW +: BW];
    end
  end

  always_comb begin
    wb_d     = wb_q;
    wr_d     = wr_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    full_d   = full_q;
    o_en_d   = o_en_q;
    o_data_d = o_data_q;
    if (wr_acc) begin
      if (wr_q == LAST) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wr_d         = '0;
      end else begin
        wr_d = wr_q + 1'b1;
      end
    end
    // Write only completes a free bank and read only releases a full one, so both updates never collide.
    if (ld) begin
      o_data_d = col;
      o_en_d   = 1'b1;
      if (rc_q == LAST) begin
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
        rc_d         = '0;
      end else begin
        rc_d = rc_q + 1'b1;
      end
    end else if (o_en_q && i_out_ready) begin
      o_en_d   = 1'b0;
      o_data_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_Reset) begin
    if (!i_Reset) begin
      wb_q     <= 1'b0;
      wr_q     <= '0;
      rb_q     <= 1'b0;
      rc_q     <= '0;
      full_q   <= 2'b00;
      o_en_q   <= 1'b0;
      o_data_q <= '0;
    end else begin
      wb_q     <= wb_d;
      wr_q     <= wr_d;
      rb_q     <= rb_d;
      rc_q     <= rc_d;
      full_q   <= full_d;
      o_en_q   <= o_en_d;
      o_data_q <= o_data_d;
    end
  end

  // Bank storage is never reset; the full flags keep stale rows unreachable.
  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem_q[wb_q][wr_q] <= i_data;
    end
  end

`ifdef TPMEM_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (i_enable && !o_ready && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_Reset) begin
    if (!i_Reset) begin
      drop_q <= 8'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign o_drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_tpmem_pingpong.sv
// Directed bench: N=4/BW=8 instance driven from a vector table plus stall/reset sequences; default-size instance streams 64 rows.
module tb_tpmem_pingpong;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [31:0]  din;
  logic         en, ordy;
  logic         rdy, oen;
  logic [31:0]  dout;
  logic [191:0] din16;
  logic         en16, ordy16;
  logic         rdy16, oen16;
  logic [191:0] dout16;
`ifdef TPMEM_DROP_CNT_EN
  logic [7:0]   drop, drop16;
`endif

  tpmem_pingpong #(.BW(8), .N(4)) dut (
    .i_clk(clk), .i_Reset(rst_n), .i_data(din), .i_enable(en), .o_ready(rdy),
    .o_data(dout), .o_en(oen),
`ifdef TPMEM_DROP_CNT_EN
    .o_drop_cnt(drop),
`endif
    .i_out_ready(ordy)
  );

  tpmem_pingpong dut16 (
    .i_clk(clk), .i_Reset(rst_n), .i_data(din16), .i_enable(en16), .o_ready(rdy16),
    .o_data(dout16), .o_en(oen16),
`ifdef TPMEM_DROP_CNT_EN
    .o_drop_cnt(drop16),
`endif
    .i_out_ready(ordy16)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  localparam logic [127:0] FA = 128'h00010203_10111213_20212223_30313233;
  localparam logic [127:0] FB = 128'h40414243_50515253_60616263_70717273;

  function automatic logic [31:0] rowof(input logic [127:0] fr, input int r);
    return fr[127-32*r -: 32];
  endfunction

  function automatic logic [31:0] col4(input logic [127:0] fr, input int k);
    logic [31:0] c;
    for (int j = 0; j < 4; j++) c[31-8*j -: 8] = fr[127-32*j-8*k -: 8];
    return c;
  endfunction

  function automatic logic [191:0] row16(input int r);
    logic [191:0] v;
    for (int k = 0; k < 16; k++) v[191-12*k -: 12] = 12'(r*37 + k*5 + 1);
    return v;
  endfunction

  function automatic logic [191:0] col16(input int c);
    logic [191:0] v;
    for (int j = 0; j < 16; j++) v[191-12*j -: 12] = 12'(((c/16)*16 + j)*37 + (c%16)*5 + 1);
    return v;
  endfunction

  typedef struct {
    logic        en;
    logic [31:0] d;
    logic        ordy;
    logic        rdy;
    logic        oen;
    logic [31:0] od;
  } vec_t;

  vec_t tbl[22];

  task automatic sv(input int i, input logic e, input logic [31:0] d, input logic o,
                    input logic r, input logic oe, input logic [31:0] od);
    tbl[i] = '{e, d, o, r, oe, od};
  endtask

  initial begin
    int acc;
    // Frame A streamed out with ready high, then frame B drained under a 1,0,1,0 ready pattern.
    sv(0,  1, 32'h00010203, 1, 1, 0, 32'h0);
    sv(1,  1, 32'h10111213, 1, 1, 0, 32'h0);
    sv(2,  1, 32'h20212223, 1, 1, 0, 32'h0);
    sv(3,  1, 32'h30313233, 1, 1, 0, 32'h0);
    sv(4,  0, 32'h0,        1, 1, 1, 32'h00102030);
    sv(5,  0, 32'h0,        1, 1, 1, 32'h01112131);
    sv(6,  0, 32'h0,        1, 1, 1, 32'h02122232);
    sv(7,  0, 32'h0,        1, 1, 1, 32'h03132333);
    sv(8,  0, 32'h0,        1, 1, 0, 32'h0);
    sv(9,  1, 32'h40414243, 0, 1, 0, 32'h0);
    sv(10, 1, 32'h50515253, 0, 1, 0, 32'h0);
    sv(11, 1, 32'h60616263, 0, 1, 0, 32'h0);
    sv(12, 1, 32'h70717273, 0, 1, 0, 32'h0);
    sv(13, 0, 32'h0,        1, 1, 1, 32'h40506070);
    sv(14, 0, 32'h0,        0, 1, 1, 32'h40506070);
    sv(15, 0, 32'h0,        1, 1, 1, 32'h41516171);
    sv(16, 0, 32'h0,        0, 1, 1, 32'h41516171);
    sv(17, 0, 32'h0,        1, 1, 1, 32'h42526272);
    sv(18, 0, 32'h0,        0, 1, 1, 32'h42526272);
    sv(19, 0, 32'h0,        1, 1, 1, 32'h43536373);
    sv(20, 0, 32'h0,        0, 1, 1, 32'h43536373);
    sv(21, 0, 32'h0,        1, 1, 0, 32'h0);

    rst_n = 1'b0; en = 0; din = '0; ordy = 0;
    en16 = 0; din16 = '0; ordy16 = 0;
    #1;
    chk("rst.rdy", 192'(rdy), 192'(1'b1));
    chk("rst.oen", 192'(oen), 192'(1'b0));
    chk("rst.dout", 192'(dout), 192'(32'h0));
`ifdef TPMEM_DROP_CNT_EN
    chk("rst.drop", 192'(drop), 192'(8'd0));
`endif
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      en = tbl[i].en; din = tbl[i].d; ordy = tbl[i].ordy;
      tick();
      chk($sformatf("vec%0d.rdy", i), 192'(rdy), 192'(tbl[i].rdy));
      chk($sformatf("vec%0d.oen", i), 192'(oen), 192'(tbl[i].oen));
      chk($sformatf("vec%0d.dout", i), 192'(dout), 192'(tbl[i].od));
    end
    en = 0;

    // Both banks fill while output is stalled; extra rows are refused.
    do_reset();
    ordy = 0; acc = 0;
    for (int i = 0; i < 12; i++) begin
      en = 1;
      din = (i < 4) ? rowof(FA, i) : (i < 8) ? rowof(FB, i-4) : (32'hDEAD0000 | 32'(i));
      if (rdy) acc++;
      tick();
    end
    en = 0;
    chk("stall.accepted", 192'(acc), 192'(8));
    chk("stall.rdy", 192'(rdy), 192'(1'b0));
    chk("stall.oen", 192'(oen), 192'(1'b1));
    chk("stall.dout", 192'(dout), 192'(col4(FA, 0)));
`ifdef TPMEM_DROP_CNT_EN
    chk("stall.drop", 192'(drop), 192'(8'd4));
`endif
    tick();
    chk("stall.hold", 192'(dout), 192'(col4(FA, 0)));
    ordy = 1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("drainA%0d.dout", k), 192'(dout), 192'(col4(FA, k)));
      chk($sformatf("drainA%0d.rdy", k), 192'(rdy), 192'(k == 3));
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("drainB%0d.dout", k), 192'(dout), 192'(col4(FB, k)));
      chk($sformatf("drainB%0d.oen", k), 192'(oen), 192'(1'b1));
    end
    tick();
    chk("drain.idle.oen", 192'(oen), 192'(1'b0));
    chk("drain.idle.dout", 192'(dout), 192'(32'h0));

    // Reset mid-frame: one full bank and a half-written bank are discarded.
    do_reset();
    ordy = 0;
    for (int i = 0; i < 6; i++) begin
      en = 1;
      din = (i < 4) ? rowof(FB, i) : rowof(FA, i-4);
      tick();
    end
    en = 0;
    chk("mid.pre.oen", 192'(oen), 192'(1'b1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid.async.oen", 192'(oen), 192'(1'b0));
    chk("mid.async.dout", 192'(dout), 192'(32'h0));
    chk("mid.async.rdy", 192'(rdy), 192'(1'b1));
    tick();
    chk("mid.held.oen", 192'(oen), 192'(1'b0));
    rst_n = 1'b1;
    ordy = 1;
    for (int i = 0; i < 4; i++) begin
      en = 1; din = rowof(FA, i);
      tick();
      chk($sformatf("mid.wr%0d.oen", i), 192'(oen), 192'(1'b0));
    end
    en = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mid.col%0d", k), 192'(dout), 192'(col4(FA, k)));
    end
    tick();
    chk("mid.end.oen", 192'(oen), 192'(1'b0));

`ifdef TPMEM_DROP_CNT_EN
    do_reset();
    ordy = 0; en = 1;
    repeat (300) tick();
    en = 0;
    chk("drop.sat", 192'(drop), 192'(8'd255));
    do_reset();
    chk("drop.clr", 192'(drop), 192'(8'd0));
`endif

    // Default-size instance: 64 back-to-back rows, continuous column stream.
    do_reset();
    ordy16 = 1;
    for (int i = 0; i <= 80; i++) begin
      en16 = (i < 64);
      din16 = row16(i);
      if (i < 64) chk($sformatf("s16.rdy%0d", i), 192'(rdy16), 192'(1'b1));
      tick();
      chk($sformatf("s16.oen%0d", i), 192'(oen16), 192'(i >= 16 && i < 80));
      chk($sformatf("s16.dout%0d", i), dout16, (i >= 16 && i < 80) ? col16(i-16) : 192'(0));
    end
    en16 = 0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tpmem_pingpong.md
TPMEM_PINGPONG -- requirements
Module: tpmem_pingpong

Interface
REQ-001 SHALL have parameter BW, default 12: bits per matrix element.
REQ-002 SHALL have parameter N, default 16: matrix dimension (rows = columns); power of two, 4..32.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port i_Reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_data  input  N*BW  one input row; element k (k=0 at MSB) occupies bits [(N-k)*BW-1 -: BW].
REQ-006 SHALL have port i_enable  input  1  input row valid.
REQ-007 SHALL have port o_ready  output  1  input row accepted when i_enable && o_ready.
REQ-008 SHALL have port o_data  output  N*BW  one output column; same lane packing as i_data, lane j = row j.
REQ-009 SHALL have port o_en  output  1  o_data valid.
REQ-010 SHALL have port i_out_ready  input  1  downstream accepts; beat transfers when o_en && i_out_ready.

Function
REQ-011 SHALL hold two banks (0,1) of N rows x N*BW bits, used ping-pong.
REQ-012 Write side SHALL keep bank pointer wb and row counter wr; accepted row written to bank[wb] row wr, wr+1.
REQ-013 On accepting row wr=N-1, SHALL set full[wb], toggle wb, clear wr to 0, all in that edge.
REQ-014 o_ready SHALL equal ~full[wb] (combinational from registers); i_enable while o_ready=0 SHALL be ignored, no state change.
REQ-015 Read side SHALL keep bank pointer rb and column counter rc; output register loads when full[rb] && (~o_en || i_out_ready).
REQ-016 A load SHALL set o_data lane j = element rc of row j of bank[rb], o_en=1, rc+1.
REQ-017 On load with rc=N-1, SHALL clear full[rb], toggle rb, clear rc to 0 (bank free once last column is registered).
REQ-018 When o_en && i_out_ready and no load occurs, SHALL set o_en=0 and o_data=0.
REQ-019 While o_en && ~i_out_ready, o_data and o_en SHALL hold.
REQ-020 Latency: last row accepted at edge T -> column 0 on o_data with o_en=1 from edge T+1 (read side idle).
REQ-021 With i_out_ready=1, SHALL sustain one row in and one column out per cycle indefinitely (full throughput).
REQ-022 Write completing one bank and read releasing the other in the same edge SHALL both take effect.
REQ-023 Both banks full SHALL deassert o_ready until the read side releases a bank; o_ready returns 1 the cycle after that release edge.
REQ-024 Read SHALL never access a bank whose full flag is clear; partially written bank is never output.

Reset
REQ-025 i_Reset=0 SHALL immediately clear wb, wr, rb, rc, full[1:0], o_en=0, o_data=0, without waiting for i_clk.
REQ-026 Bank contents SHALL NOT be reset; stale contents are never observable (REQ-024).
REQ-027 Reset mid-frame SHALL discard all partial and full banks; first row after release goes to bank 0 row 0.
REQ-028 o_ready SHALL be 1 during and after reset.

Configuration
REQ-029 Macro TPMEM_DROP_CNT_EN defined: SHALL add output o_drop_cnt (8 bits), +1 per cycle with i_enable && ~o_ready, saturating at 255, cleared by reset.
REQ-030 Macro undefined: port o_drop_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 N=4, BW=8, i_out_ready=1: rows 0x00010203,0x10111213,0x20212223,0x30313233 -> columns 0x00102030,0x01112131,0x02122232,0x03132333 from edge T+1, one per cycle.
REQ-032 Default N=16,BW=12: 64 back-to-back rows, i_out_ready=1 -> o_ready stays 1, 64 correct columns, no gap after first.
REQ-033 N=4, i_out_ready=0, 12 rows offered -> 8 accepted, o_ready=0 after 8th, o_data holds column 0 of frame 0; with TPMEM_DROP_CNT_EN o_drop_cnt=4.
REQ-034 N=4, i_out_ready toggling 1,0,1,0 -> each column held while stalled, no column lost or duplicated.
REQ-035 Reset asserted after 2 of 4 rows, then full frame -> output only the new frame, first row in bank 0; o_en 0 during reset.
REQ-036 N=4, 300 rows with i_out_ready=0 under TPMEM_DROP_CNT_EN -> o_drop_cnt saturates at 255.
